// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo write-port arbiter: state encoding,
// statistics counter width and a width helper that never returns zero.
package fifo_arb_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   localparam int STAT_W = 16;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_GRANT = ST_GRANT
   } arb_state_t;

   // $clog2 collapses to 0 for a value of 1; register fields need >= 1 bit.
   function automatic int clog2_safe(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: first set request strictly after last_owner,
// wrapping modulo N. Purely combinational.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]               req,
   input  logic [clog2_safe(N)-1:0]   last_owner,
   output logic                       found,
   output logic [clog2_safe(N)-1:0]   next_owner
);

   localparam int OW = clog2_safe(N);

   logic [OW-1:0] idx;

   always_comb begin
      found      = 1'b0;
      next_owner = '0;
      idx        = '0;
      for (int i = 1; i <= N; i++) begin
         idx = OW'((int'(last_owner) + i) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            next_owner = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N producers, with
// bursts of up to BURST words per grant. FIFO_ARB_STATS_EN adds wr_count.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int B     = 8,
   parameter int BURST = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       req,
   input  logic [N*B-1:0]     w_data_in,
   output logic [N-1:0]       ack,
   output logic [N-1:0]       grant,
   output logic               fifo_wr,
   output logic [B-1:0]       fifo_w_data,
   input  logic               fifo_full,
   output logic               busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [N*STAT_W-1:0] wr_count
`endif
);

   localparam int OW = clog2_safe(N);
   localparam int CW = clog2_safe(BURST + 1);
   localparam logic [CW-1:0] LAST_WORD = CW'(BURST - 1);
   localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);

   arb_state_t    state;
   logic [OW-1:0] owner;
   logic [OW-1:0] last_owner;
   logic [CW-1:0] burst_cnt;
   logic          found;
   logic [OW-1:0] next_owner;
   logic          owner_req;
   logic          write;

   rr_pick #(.N(N)) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .found      (found),
      .next_owner (next_owner)
   );

   // Writes are suppressed in the reset cycle even if a grant is still held.
   assign owner_req   = req[owner];
   assign write       = (state == S_GRANT) & owner_req & ~fifo_full & ~reset;
   assign fifo_wr     = write;
   assign ack         = write ? (N'(1) << owner) : '0;
   assign fifo_w_data = w_data_in[owner*B +: B];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         owner      <= '0;
         last_owner <= LAST_IDX;
         burst_cnt  <= '0;
         grant      <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  state     <= S_GRANT;
                  owner     <= next_owner;
                  burst_cnt <= '0;
                  grant     <= N'(1) << next_owner;
                  busy      <= 1'b1;
               end
            end
            S_GRANT: begin
               if (!owner_req || (write && burst_cnt == LAST_WORD)) begin
                  state      <= S_IDLE;
                  last_owner <= owner;
                  burst_cnt  <= '0;
                  grant      <= '0;
                  busy       <= 1'b0;
               end else if (write) begin
                  burst_cnt <= burst_cnt + CW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] wr_cnt [N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) wr_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (ack[i] && (wr_cnt[i] != '1)) wr_cnt[i] <= wr_cnt[i] + STAT_W'(1);
         end
      end
   end

   always_comb begin
      wr_count = '0;
      for (int i = 0; i < N; i++) wr_count[i*STAT_W +: STAT_W] = wr_cnt[i];
   end
`endif

endmodule
